// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Takes the keypad scanner's per-frame key report, debounces each press and release,
//   and turns the accepted keys into decimal number entry for the game core.
//   Digits 0-9 append to the entry, E is backspace, F submits the entry, A-D emit a
//   one-cycle command pulse.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   key_valid    scanner reports a key down
//   key_code     code of the key that is down (0-F)
//   clear        one-cycle pulse: empty the entry being typed
//   entry_value  number currently being typed (live display)
//   digit_count  number of digits in entry_value
//   num_valid    a completed number is waiting for the consumer
//   num_value    the completed number, stable while num_valid is high
//   num_ready    consumer accepts num_value on this edge
//   cmd_valid    one-cycle pulse for keys A-D
//   cmd_code     A=0 .. D=3, holds the last command
//   err          one-cycle pulse when an accepted key is rejected
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int MAX_DIGITS      = 3,
  parameter int VAL_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             clear,
  output logic [VAL_W-1:0] entry_value,
  output logic [2:0]       digit_count,
  output logic             num_valid,
  output logic [VAL_W-1:0] num_value,
  input  logic             num_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  output logic             err
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int WIDE_W = VAL_W + 4;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       MAX_CNT   = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept;

  logic [VAL_W-1:0] entry_q, entry_d;
  logic [2:0]       count_q, count_d;
  logic             num_valid_q, num_valid_d;
  logic [VAL_W-1:0] num_value_q, num_value_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_code_q, cmd_code_d;
  logic             err_q, err_d;

  logic [WIDE_W-1:0] times10_plus;
  logic [WIDE_W-1:0] div10;
  logic              key_is_cmd;
  logic              entry_act;

  // ---------------- debounce FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          cand_d  = key_code;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key_valid && key_code == cand_q) begin
          // The match on the last count is the accept: the action lands on this edge.
          if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!key_valid) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A key reappearing during release is treated as bounce of the same press.
        if (key_valid) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- entry datapath ----------------
  assign times10_plus = WIDE_W'(entry_q) * WIDE_W'(10) + WIDE_W'(cand_q);
  assign div10        = WIDE_W'(entry_q) / WIDE_W'(10);
  assign key_is_cmd   = (cand_q >= 4'hA) && (cand_q <= 4'hD);
  // clear overrides digit/E/F actions completely (including their err), but not commands.
  assign entry_act    = accept && !clear && !key_is_cmd;

  always_comb begin
    entry_d     = entry_q;
    count_d     = count_q;
    num_valid_d = num_valid_q && !num_ready;
    num_value_d = num_value_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    err_d       = 1'b0;

    if (entry_act) begin
      if (cand_q <= 4'd9) begin
        if (count_q < MAX_CNT) begin
          entry_d = VAL_W'(times10_plus);
          count_d = count_q + 3'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (cand_q == 4'hE) begin
        if (count_q != 3'd0) begin
          entry_d = VAL_W'(div10);
          count_d = count_q - 3'd1;
        end
      end else begin
        // Enter: an empty entry or a still-unaccepted previous number is an error.
        // With num_ready high the old number completes on this edge and the new one loads.
        if (count_q == 3'd0) begin
          err_d = 1'b1;
        end else if (num_valid_q && !num_ready) begin
          err_d = 1'b1;
        end else begin
          num_value_d = entry_q;
          num_valid_d = 1'b1;
          entry_d     = '0;
          count_d     = 3'd0;
        end
      end
    end

    if (accept && key_is_cmd) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = cand_q[1:0] - 2'd2;  // A(..10)->0, B->1, C->2, D->3
    end

    if (clear) begin
      entry_d = '0;
      count_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q     <= '0;
      count_q     <= 3'd0;
      num_valid_q <= 1'b0;
      num_value_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      count_q     <= count_d;
      num_valid_q <= num_valid_d;
      num_value_q <= num_value_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      err_q       <= err_d;
    end
  end

  assign entry_value = entry_q;
  assign digit_count = count_q;
  assign num_valid   = num_valid_q;
  assign num_value   = num_value_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;

  localparam int DC   = 4;
  localparam int MAXD = 3;
  localparam int VW   = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          clear = 1'b0;
  logic          num_ready = 1'b0;
  logic [VW-1:0] entry_value;
  logic [2:0]    digit_count;
  logic          num_valid;
  logic [VW-1:0] num_value;
  logic          cmd_valid;
  logic [1:0]    cmd_code;
  logic          err;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .MAX_DIGITS     (MAXD),
    .VAL_W          (VW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .clear      (clear),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .num_valid  (num_valid),
    .num_value  (num_value),
    .num_ready  (num_ready),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int cmd_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce as run lengths: a press is accepted after DC+1 consecutive samples of the
  // same key starting from an unlocked state; once accepted, input is ignored until
  // DC+1 consecutive empty samples have been seen. The entry is kept as a list of digits.
  int m_digits[$];
  bit m_locked;
  int m_run, m_zrun, m_code;
  bit m_nv;
  int m_nval;
  bit m_cmd;
  int m_ccode;
  bit m_err;

  function automatic int val_of();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_locked = 0; m_run = 0; m_zrun = 0; m_code = 0;
    m_nv = 0; m_nval = 0; m_cmd = 0; m_ccode = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit acc = 0;
    bit nv_old = m_nv;
    m_err = 0;
    m_cmd = 0;
    if (!m_locked) begin
      if (m_run == 0) begin
        if (key_valid) begin m_code = int'(key_code); m_run = 1; end
      end else if (key_valid && int'(key_code) == m_code) begin
        m_run++;
        if (m_run == DC + 1) begin acc = 1; m_locked = 1; m_run = 0; m_zrun = 0; end
      end else begin
        m_run = 0;
      end
    end else begin
      if (key_valid) m_zrun = 0;
      else begin
        m_zrun++;
        if (m_zrun == DC + 1) begin m_locked = 0; m_zrun = 0; end
      end
    end

    if (nv_old && num_ready) m_nv = 0;
    if (acc) begin
      if (m_code >= 10 && m_code <= 13) begin
        m_cmd = 1;
        m_ccode = m_code - 10;
      end else if (!clear) begin
        if (m_code <= 9) begin
          if (m_digits.size() < MAXD) m_digits.push_back(m_code);
          else m_err = 1;
        end else if (m_code == 14) begin
          if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else begin
          if (m_digits.size() == 0) m_err = 1;
          else if (nv_old && !num_ready) m_err = 1;
          else begin
            m_nval = val_of();
            m_nv = 1;
            m_digits.delete();
          end
        end
      end
    end
    if (clear) m_digits.delete();
  endtask

  // Per-cycle compare, 2ns after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #2;
      chk("entry_value", int'(entry_value), val_of());
      chk("digit_count", int'(digit_count), m_digits.size());
      chk("num_valid", int'(num_valid), int'(m_nv));
      chk("num_value", int'(num_value), m_nval);
      chk("cmd_valid", int'(cmd_valid), int'(m_cmd));
      chk("cmd_code", int'(cmd_code), m_ccode);
      chk("err", int'(err), int'(m_err));
      if (err) err_pulses++;
      if (cmd_valid) cmd_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input int code, input int hold, input int rel);
    key_code  = 4'(code);
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  int c0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_entry", int'(entry_value), 0);
    chk("rst_numvalid", int'(num_valid), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: digits with latency pinned on the first press
    key_code = 4'd1; key_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("lat_before", int'(entry_value), 0);
    @(negedge clk);
    chk("lat_at", int'(entry_value), 1);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_entry1", int'(entry_value), 1);
    press(2, 6, 6);
    chk("t1_entry2", int'(entry_value), 12);
    press(3, 6, 6);
    chk("t1_entry3", int'(entry_value), 123);
    chk("t1_count3", int'(digit_count), 3);
    $display("t1 digits: entry=%0d count=%0d", entry_value, digit_count);

    // 2: overflow digit, backspace, enter
    press(4, 6, 6);
    chk("t2_errcnt", err_pulses, 1);
    chk("t2_entry", int'(entry_value), 123);
    press(14, 6, 6);
    chk("t2_bksp", int'(entry_value), 12);
    press(15, 6, 6);
    chk("t2_nv", int'(num_valid), 1);
    chk("t2_nval", int'(num_value), 12);
    chk("t2_entry0", int'(entry_value), 0);
    $display("t2 enter: num_value=%0d num_valid=%0d", num_value, num_valid);

    // 3: enter blocked while pending; then enter coinciding with num_ready
    press(5, 6, 6);
    press(15, 6, 6);
    chk("t3_errcnt", err_pulses, 2);
    chk("t3_entry", int'(entry_value), 5);
    chk("t3_nval_kept", int'(num_value), 12);
    key_code = 4'hF; key_valid = 1'b1;
    repeat (4) @(negedge clk);
    num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_nv", int'(num_valid), 1);
    chk("t3_nval", int'(num_value), 5);
    num_ready = 1'b1;
    @(negedge clk);
    num_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained", int'(num_valid), 0);
    $display("t3 handshake: num_value=%0d num_valid=%0d", num_value, num_valid);

    // 4: press bounce and release glitch
    key_code = 4'd7; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    repeat (6) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_entry", int'(entry_value), 7);
    chk("t4_count", int'(digit_count), 1);
    $display("t4 bounce: entry=%0d count=%0d", entry_value, digit_count);

    // 5: command key, short and long hold
    c0 = cmd_pulses;
    press(11, 6, 6);
    chk("t5_pulses1", cmd_pulses, c0 + 1);
    chk("t5_code", int'(cmd_code), 1);
    chk("t5_entry", int'(entry_value), 7);
    press(11, 50, 6);
    chk("t5_pulses2", cmd_pulses, c0 + 2);
    $display("t5 cmd: pulses=%0d code=%0d", cmd_pulses - c0, cmd_code);

    // 6: clear on the accept edge of digit 9
    key_code = 4'd9; key_valid = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_entry", int'(entry_value), 0);
    chk("t6_count", int'(digit_count), 0);
    chk("t6_errcnt", err_pulses, 2);
    $display("t6 clear: entry=%0d count=%0d", entry_value, digit_count);

    // boundaries on an empty entry: backspace is silent, enter is an error
    press(14, 6, 6);
    chk("b_bksp_err", err_pulses, 2);
    press(15, 6, 6);
    chk("b_enter_err", err_pulses, 3);
    $display("boundary: err_pulses=%0d", err_pulses);

    // async reset in the middle of a debounce; key held across reset is a new press
    press(6, 6, 6);
    chk("r_pre", int'(entry_value), 6);
    key_code = 4'd3; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_entry", int'(entry_value), 0);
    chk("r_count", int'(digit_count), 0);
    chk("r_cmdcode", int'(cmd_code), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    key_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("r_repress", int'(entry_value), 3);
    $display("reset: entry after re-press=%0d", entry_value);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
